// File: rtl/bus_xfer_arbiter_pkg.sv
// Shared codes, state encoding and helpers for the bus transfer arbiter.
// Replaces the bus_defs.vh header.
package bus_xfer_arbiter_pkg;

  localparam logic [1:0] SRC_AR  = 2'd0;
  localparam logic [1:0] SRC_DR  = 2'd1;
  localparam logic [1:0] SRC_PC  = 2'd2;
  localparam logic [1:0] DST_INV = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_LOAD  = 2'd2
  } state_e;

  function automatic logic [1:0] nxt3(input logic [1:0] c);
    return (c == SRC_PC) ? SRC_AR : c + 2'd1;
  endfunction

  function automatic logic [2:0] onehot3(input logic [1:0] c);
    return 3'b001 << c;
  endfunction

  function automatic logic [1:0] dst_of(input logic [5:0] d,
                                        input logic [1:0] c);
    case (c)
      SRC_AR:  return d[1:0];
      SRC_DR:  return d[3:2];
      default: return d[5:4];
    endcase
  endfunction

  // A source may not load itself, and code 3 names no register.
  function automatic logic dst_ok(input logic [1:0] w,
                                  input logic [1:0] d);
    return (d != w) && (d != DST_INV);
  endfunction

endpackage

// File: rtl/bus_xfer_arbiter_rr_pick3.sv
// Combinational 3-way round-robin picker starting at ptr.
// ptr=0 gives fixed priority AR > DR > PC.
module rr_pick3
  import bus_xfer_arbiter_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic [2:0] pick,
  output logic [1:0] code,
  output logic       valid
);

  logic [1:0] p0, p1, p2;

  always_comb begin
    p0 = (ptr == DST_INV) ? SRC_AR : ptr;
    p1 = nxt3(p0);
    p2 = nxt3(p1);
    code  = p0;
    valid = 1'b0;
    if ((req & onehot3(p0)) != 3'b000) begin
      code  = p0;
      valid = 1'b1;
    end else if ((req & onehot3(p1)) != 3'b000) begin
      code  = p1;
      valid = 1'b1;
    end else if ((req & onehot3(p2)) != 3'b000) begin
      code  = p2;
      valid = 1'b1;
    end
    pick = valid ? onehot3(code) : 3'b000;
  end

endmodule

// File: rtl/bus_xfer_arbiter.sv
// Shared 16-bit bus arbiter for AR/DR/PC: grant, settle, load, ack.
// BUS_ARB_RR_EN selects round-robin; otherwise fixed AR > DR > PC.
module bus_xfer_arbiter
  import bus_xfer_arbiter_pkg::*;
#(
  parameter int SETTLE = 1,
  parameter int CNT_W  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  input  logic [5:0] req_dst,
  output logic [1:0] sel,
  output logic       bus_en,
  output logic [2:0] gnt,
  output logic       ld_ar,
  output logic       ld_dr,
  output logic       ld_pc,
  output logic [2:0] ack,
  output logic       err,
  output logic       busy
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         win_q, win_d;
  logic [1:0]         dst_q, dst_d;
  logic [1:0]         sel_q, sel_d;
  logic               bus_en_q, bus_en_d;
  logic [2:0]         gnt_q, gnt_d;
  logic [2:0]         ld_q, ld_d;
  logic [2:0]         ack_q, ack_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;

`ifdef BUS_ARB_RR_EN
  logic [1:0]         ptr_q, ptr_d;
`else
  logic [1:0]         ptr_q;
  assign ptr_q = SRC_AR;
`endif

  logic [2:0]         pk_onehot;
  logic [1:0]         pk_code;
  logic               pk_vld;
  logic [1:0]         pk_dst;

  rr_pick3 u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .pick  (pk_onehot),
    .code  (pk_code),
    .valid (pk_vld)
  );

  assign pk_dst = dst_of(req_dst, pk_code);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    win_d    = win_q;
    dst_d    = dst_q;
    sel_d    = sel_q;
    bus_en_d = bus_en_q;
    gnt_d    = gnt_q;
    busy_d   = busy_q;
    ld_d     = 3'b000;
    ack_d    = 3'b000;
    err_d    = 1'b0;
`ifdef BUS_ARB_RR_EN
    ptr_d    = ptr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pk_vld) begin
          if (!dst_ok(pk_code, pk_dst)) begin
            err_d = 1'b1;
            ack_d = pk_onehot;
`ifdef BUS_ARB_RR_EN
            ptr_d = nxt3(pk_code);
`endif
          end else begin
            state_d  = ST_GRANT;
            cnt_d    = CNT_W'(SETTLE - 1);
            win_d    = pk_code;
            dst_d    = pk_dst;
            sel_d    = pk_code;
            bus_en_d = 1'b1;
            gnt_d    = pk_onehot;
            busy_d   = 1'b1;
          end
        end
      end
      ST_GRANT: begin
        // Owner withdrew: release the bus without loading anything.
        if ((req & onehot3(win_q)) == 3'b000) begin
          state_d  = ST_IDLE;
          sel_d    = SRC_AR;
          bus_en_d = 1'b0;
          gnt_d    = 3'b000;
          busy_d   = 1'b0;
        end else if (cnt_q == '0) begin
          state_d = ST_LOAD;
          ld_d    = onehot3(dst_q);
          ack_d   = onehot3(win_q);
`ifdef BUS_ARB_RR_EN
          ptr_d   = nxt3(win_q);
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_LOAD: begin
        state_d  = ST_IDLE;
        sel_d    = SRC_AR;
        bus_en_d = 1'b0;
        gnt_d    = 3'b000;
        busy_d   = 1'b0;
      end
      default: begin
        state_d  = ST_IDLE;
        sel_d    = SRC_AR;
        bus_en_d = 1'b0;
        gnt_d    = 3'b000;
        busy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      win_q    <= SRC_AR;
      dst_q    <= SRC_AR;
      sel_q    <= SRC_AR;
      bus_en_q <= 1'b0;
      gnt_q    <= 3'b000;
      ld_q     <= 3'b000;
      ack_q    <= 3'b000;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
`ifdef BUS_ARB_RR_EN
      ptr_q    <= SRC_AR;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      win_q    <= win_d;
      dst_q    <= dst_d;
      sel_q    <= sel_d;
      bus_en_q <= bus_en_d;
      gnt_q    <= gnt_d;
      ld_q     <= ld_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
`ifdef BUS_ARB_RR_EN
      ptr_q    <= ptr_d;
`endif
    end
  end

  assign sel    = sel_q;
  assign bus_en = bus_en_q;
  assign gnt    = gnt_q;
  assign ld_ar  = ld_q[0];
  assign ld_dr  = ld_q[1];
  assign ld_pc  = ld_q[2];
  assign ack    = ack_q;
  assign err    = err_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_bus_xfer_arbiter.sv
// Bench for bus_xfer_arbiter: vector table, scoreboard on u1 acks,
// hand sequences for reset, abort, contention and settle window.
module tb_bus_xfer_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [2:0] req1, req3, req4;
  logic [5:0] dst1, dst3, dst4;
  logic [1:0] sel1, sel3, sel4;
  logic       ben1, ben3, ben4;
  logic [2:0] gnt1, gnt3, gnt4;
  logic       lar1, lar3, lar4;
  logic       ldr1, ldr3, ldr4;
  logic       lpc1, lpc3, lpc4;
  logic [2:0] ack1, ack3, ack4;
  logic       err1, err3, err4;
  logic       bsy1, bsy3, bsy4;

  bus_xfer_arbiter #(.SETTLE(1), .CNT_W(4)) u1 (
    .clk(clk), .rst(rst), .req(req1), .req_dst(dst1),
    .sel(sel1), .bus_en(ben1), .gnt(gnt1),
    .ld_ar(lar1), .ld_dr(ldr1), .ld_pc(lpc1),
    .ack(ack1), .err(err1), .busy(bsy1));

  bus_xfer_arbiter #(.SETTLE(3), .CNT_W(4)) u3 (
    .clk(clk), .rst(rst), .req(req3), .req_dst(dst3),
    .sel(sel3), .bus_en(ben3), .gnt(gnt3),
    .ld_ar(lar3), .ld_dr(ldr3), .ld_pc(lpc3),
    .ack(ack3), .err(err3), .busy(bsy3));

  bus_xfer_arbiter #(.SETTLE(4), .CNT_W(4)) u4 (
    .clk(clk), .rst(rst), .req(req4), .req_dst(dst4),
    .sel(sel4), .bus_en(ben4), .gnt(gnt4),
    .ld_ar(lar4), .ld_dr(ldr4), .ld_pc(lpc4),
    .ack(ack4), .err(err4), .busy(bsy4));

  typedef struct {
    logic [2:0] req;
    logic [5:0] dst;
    logic [2:0] gnt;
    logic [1:0] sel;
    logic [2:0] ld;
    logic [2:0] ack;
    logic       err;
    int         lat;
  } vec_t;

  typedef struct {
    logic [2:0] ack;
    logic [2:0] ld;
    logic [1:0] sel;
    logic       err;
  } exp_t;

  exp_t sbq[$];
  vec_t vecs[9];

  task automatic chk(input string name, input int unsigned act,
                     input int unsigned exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard for u1: every ack must match the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (!$onehot0(gnt1) || !$onehot0({lpc1, ldr1, lar1}))
        chk("u1_onehot", {gnt1, lpc1, ldr1, lar1}, 0);
      if (ack1 != 3'b000) begin
        if (sbq.size() == 0) begin
          chk("u1_unexpected_ack", ack1, 0);
        end else begin
          e = sbq.pop_front();
          chk("sb_ack", ack1, e.ack);
          chk("sb_ld", {lpc1, ldr1, lar1}, e.ld);
          chk("sb_err", err1, e.err);
          if (!e.err) chk("sb_sel", sel1, e.sel);
        end
      end
    end
  end

  task automatic do_reset();
    rst  = 1'b1;
    req1 = '0; req3 = '0; req4 = '0;
    dst1 = '0; dst3 = '0; dst4 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push(input logic [2:0] a, input logic [2:0] l,
                      input logic [1:0] s, input logic e);
    exp_t x;
    x.ack = a; x.ld = l; x.sel = s; x.err = e;
    sbq.push_back(x);
  endtask

  initial begin
    bit got;
    int nack, gcnt, ldcnt, ldpos;
    bit seen, prev_ack;
    logic [2:0] ackv;

    // dst layout {PC, DR, AR}; ld layout {pc, dr, ar}
    vecs[0] = '{3'b100, 6'b01_00_00, 3'b100, 2'd2, 3'b010, 3'b100, 1'b0, 2};
    vecs[1] = '{3'b001, 6'b00_00_10, 3'b001, 2'd0, 3'b100, 3'b001, 1'b0, 2};
    vecs[2] = '{3'b010, 6'b00_00_00, 3'b010, 2'd1, 3'b001, 3'b010, 1'b0, 2};
    vecs[3] = '{3'b010, 6'b00_01_00, 3'b000, 2'd0, 3'b000, 3'b010, 1'b1, 1};
    vecs[4] = '{3'b010, 6'b00_11_00, 3'b000, 2'd0, 3'b000, 3'b010, 1'b1, 1};
    vecs[5] = '{3'b001, 6'b00_00_00, 3'b000, 2'd0, 3'b000, 3'b001, 1'b1, 1};
    vecs[6] = '{3'b100, 6'b10_00_00, 3'b000, 2'd0, 3'b000, 3'b100, 1'b1, 1};
    vecs[7] = '{3'b110, 6'b00_10_00, 3'b010, 2'd1, 3'b100, 3'b010, 1'b0, 2};
    vecs[8] = '{3'b101, 6'b00_00_01, 3'b001, 2'd0, 3'b010, 3'b001, 1'b0, 2};

    rst = 1'b0;
    req1 = '0; req3 = '0; req4 = '0;
    dst1 = '0; dst3 = '0; dst4 = '0;
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_u1", {sel1, ben1, gnt1, lar1, ldr1, lpc1, ack1, err1, bsy1}, 0);
    chk("rst_u3", {sel3, ben3, gnt3, lar3, ldr3, lpc3, ack3, err3, bsy3}, 0);
    chk("rst_u4", {sel4, ben4, gnt4, lar4, ldr4, lpc4, ack4, err4, bsy4}, 0);
    rst = 1'b0;

    // Table: single requests from a fresh reset on the SETTLE=1 unit
    for (int i = 0; i < 9; i++) begin
      do_reset();
      req1 = vecs[i].req;
      dst1 = vecs[i].dst;
      push(vecs[i].ack, vecs[i].ld, vecs[i].sel, vecs[i].err);
      got = 0;
      for (int n = 1; n <= 8; n++) begin
        @(negedge clk);
        if (n == 1) chk($sformatf("v%0d_gnt", i), gnt1, vecs[i].gnt);
        if (ack1 != 3'b000) begin
          chk($sformatf("v%0d_lat", i), n, vecs[i].lat);
          req1 = '0;
          got = 1;
          break;
        end
      end
      if (!got) chk($sformatf("v%0d_ack_timeout", i), 0, 1);
      @(negedge clk);
      chk($sformatf("v%0d_busy_after", i), bsy1, 0);
    end

    // Contention: all three requests held for four transfers
    do_reset();
    dst1 = 6'b00_10_01;
`ifdef BUS_ARB_RR_EN
    push(3'b001, 3'b010, 2'd0, 1'b0);
    push(3'b010, 3'b100, 2'd1, 1'b0);
    push(3'b100, 3'b001, 2'd2, 1'b0);
    push(3'b001, 3'b010, 2'd0, 1'b0);
`else
    repeat (4) push(3'b001, 3'b010, 2'd0, 1'b0);
`endif
    req1 = 3'b111;
    nack = 0;
    prev_ack = 0;
    for (int n = 0; n < 40 && nack < 4; n++) begin
      @(negedge clk);
      if (prev_ack) chk("cont_idle_gap", bsy1, 0);
      prev_ack = (ack1 != 3'b000);
      if (prev_ack) nack++;
    end
    req1 = '0;
    chk("cont_acks", nack, 4);
    repeat (4) @(negedge clk);
    chk("cont_sb_empty", sbq.size(), 0);

    // Reset in the middle of a grant
    do_reset();
    req4 = 3'b001;
    dst4 = 6'b00_00_01;
    @(negedge clk);
    chk("rmid_gnt", gnt4, 3'b001);
    @(negedge clk);
    rst = 1'b1;
    req4 = '0;
    #1;
    chk("rmid_outs", {sel4, ben4, gnt4, lar4, ldr4, lpc4, ack4, err4, bsy4}, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (ack4 != 3'b000 || {lar4, ldr4, lpc4} != 3'b000) seen = 1;
    end
    chk("rmid_no_load", seen, 0);

    // Abort: owner drops req two cycles into the settle window
    do_reset();
    req4 = 3'b001;
    dst4 = 6'b00_00_01;
    @(negedge clk);
    chk("abort_gnt", gnt4, 3'b001);
    repeat (2) @(negedge clk);
    req4 = '0;
    @(negedge clk);
    chk("abort_gnt_clr", gnt4, 0);
    chk("abort_ben_clr", ben4, 0);
    chk("abort_busy_clr", bsy4, 0);
    seen = 0;
    repeat (8) begin
      if (ack4 != 3'b000 || {lar4, ldr4, lpc4} != 3'b000) seen = 1;
      @(negedge clk);
    end
    chk("abort_no_load", seen, 0);

    // Settle window: SETTLE=3, AR loads PC
    do_reset();
    req3 = 3'b001;
    dst3 = 6'b00_00_10;
    gcnt = 0; ldcnt = 0; ldpos = 0; ackv = '0;
    repeat (12) begin
      @(negedge clk);
      if (gnt3 == 3'b001) gcnt++;
      if (lpc3) begin
        ldcnt++;
        ldpos = gcnt;
      end
      if (ack3 != 3'b000) begin
        ackv = ack3;
        req3 = '0;
      end
    end
    chk("settle_gnt_cycles", gcnt, 4);
    chk("settle_ld_count", ldcnt, 1);
    chk("settle_ld_pos", ldpos, 4);
    chk("settle_ack", ackv, 3'b001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
